// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        StIdle        = 2'd0,
        StPressWait   = 2'd1,
        StPressed     = 2'd2,
        StReleaseWait = 2'd3
    } btn_state_e;

    // Defaults assume a 100 MHz clock: 10 ms debounce, 2 s long press.
    localparam int unsigned STABLE_CYCLES_DEF = 1_000_000;
    localparam int unsigned LONG_CYCLES_DEF   = 200_000_000;
    localparam int unsigned N_BTN_DEF         = 3;

    localparam int unsigned BTN_ENTER = 0;
    localparam int unsigned BTN_OOPS  = 1;
    localparam int unsigned BTN_RST   = 2;

endpackage

// File: rtl/btn_conditioner_if.sv
// Raw button inputs and conditioned outputs; master drives buttons, slave is the conditioner.
interface btn_conditioner_if #(
    parameter int unsigned N_BTN = 3
);
    logic [N_BTN-1:0] btn_i;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_long;

    modport master (
        output btn_i,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    modport slave (
        input  btn_i,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long
    );
endinterface

// File: rtl/btn_channel.sv
// One button: 2-FF synchroniser, 4-state debounce FSM, registered level/press/release pulses.
// Optional hold counter and long-press pulse when BTN_LONGPRESS_EN is defined.
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);
    localparam int unsigned     CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_cfg_check
        $error("btn_channel: STABLE_CYCLES and LONG_CYCLES must be >= 2");
    end

    logic             meta_q, sync_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q    <= 1'b0;
            sync_q    <= 1'b0;
            state_q   <= StIdle;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            meta_q    <= btn_i;
            sync_q    <= meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sync_q) begin
                    state_d = StPressWait;
                    cnt_d   = CNT_W'(1);
                end
            end
            StPressWait: begin
                if (!sync_q) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StPressed: begin
                if (!sync_q) begin
                    state_d = StReleaseWait;
                    cnt_d   = CNT_W'(1);
                end
            end
            StReleaseWait: begin
                if (sync_q) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef BTN_LONGPRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;
    logic              holding;

    // Hold counter restarts only on a fresh qualified press, so release bounces
    // (ReleaseWait -> Pressed) cannot retrigger the long pulse.
    always_comb begin
        holding = (state_q == StPressed) || (state_q == StReleaseWait);
        hold_d  = hold_q;
        long_d  = 1'b0;
        if (state_q == StPressWait && state_d == StPressed) begin
            hold_d = '0;
        end else if (holding && hold_q != HOLD_W'(LONG_CYCLES)) begin
            hold_d = hold_q + HOLD_W'(1);
        end
        if (holding && hold_q == HOLD_W'(LONG_CYCLES - 1)) begin
            long_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: N_BTN independent synchronise/debounce channels.
// Define BTN_LONGPRESS_EN to enable the per-channel long-press pulse.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN         = N_BTN_DEF,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF
) (
    input logic              clk,
    input logic              rst_n,
    btn_conditioner_if.slave bus
);
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] rel;
    logic [N_BTN-1:0] lng;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_i    (bus.btn_i[i]),
            .level_o  (level[i]),
            .press_o  (press[i]),
            .release_o(rel[i]),
            .long_o   (lng[i])
        );
    end

    assign bus.btn_level   = level;
    assign bus.btn_press   = press;
    assign bus.btn_release = rel;
    assign bus.btn_long    = lng;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with STABLE_CYCLES=4, LONG_CYCLES=16.
module tb_btn_conditioner;
    import btn_pkg::*;

    localparam int unsigned N   = 3;
    localparam int unsigned SC  = 4;
    localparam int unsigned LC  = 16;
    localparam int          LAT = SC + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    btn_conditioner_if #(.N_BTN(N)) bus ();

    btn_conditioner #(
        .N_BTN        (N),
        .STABLE_CYCLES(SC),
        .LONG_CYCLES  (LC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int           cyc;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] lng;
        logic [N-1:0] level;
    } ev_t;

    ev_t exp_q[$];
    ev_t e;
    int  cyc     = 0;
    int  n_tests = 0;
    int  n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: any pulse output consumes one expected event.
    always @(negedge clk) begin
        if (rst_n && (bus.btn_press | bus.btn_release | bus.btn_long) != '0) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse cyc=%0d got press=%b rel=%b long=%b, required none",
                         cyc, bus.btn_press, bus.btn_release, bus.btn_long);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || bus.btn_press !== e.press || bus.btn_release !== e.rel ||
                    bus.btn_long !== e.lng || bus.btn_level !== e.level) begin
                    n_fail++;
                    $display("FAIL event got cyc=%0d press=%b rel=%b long=%b level=%b, required cyc=%0d press=%b rel=%b long=%b level=%b",
                             cyc, bus.btn_press, bus.btn_release, bus.btn_long, bus.btn_level,
                             e.cyc, e.press, e.rel, e.lng, e.level);
                end
            end
        end
    end

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic push(input int c, input logic [N-1:0] p, input logic [N-1:0] r,
                        input logic [N-1:0] l, input logic [N-1:0] lv);
        ev_t x;
        x.cyc   = c;
        x.press = p;
        x.rel   = r;
        x.lng   = l;
        x.level = lv;
        exp_q.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"},   bus.btn_level,   '0);
        check({tag, "_press"},   bus.btn_press,   '0);
        check({tag, "_release"}, bus.btn_release, '0);
        check({tag, "_long"},    bus.btn_long,    '0);
    endtask

    initial begin
        int c;
        bus.btn_i = '0;
        tick(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(4);

        // Clean press and release on enter.
        bus.btn_i[BTN_ENTER] = 1'b1;
        push(cyc + LAT, 3'b001, 3'b000, 3'b000, 3'b001);
        tick(10);
        bus.btn_i[BTN_ENTER] = 1'b0;
        push(cyc + LAT, 3'b000, 3'b001, 3'b000, 3'b000);
        tick(10);
        check("clean_level_after", bus.btn_level, 3'b000);

        // Bounce on oops: two short highs rejected, final rise qualifies.
        for (int k = 0; k < 2; k++) begin
            bus.btn_i[BTN_OOPS] = 1'b1;
            tick(2);
            bus.btn_i[BTN_OOPS] = 1'b0;
            tick(2);
        end
        bus.btn_i[BTN_OOPS] = 1'b1;
        push(cyc + LAT, 3'b010, 3'b000, 3'b000, 3'b010);
        tick(10);
        check("bounce_level_held", bus.btn_level, 3'b010);
        bus.btn_i[BTN_OOPS] = 1'b0;
        push(cyc + LAT, 3'b000, 3'b010, 3'b000, 3'b000);
        tick(10);

        // Glitch of 3 cycles on reset-request: no output change.
        bus.btn_i[BTN_RST] = 1'b1;
        tick(3);
        bus.btn_i[BTN_RST] = 1'b0;
        tick(10);
        check("glitch_level", bus.btn_level, 3'b000);

        // Simultaneous press/release on all channels.
        bus.btn_i = 3'b111;
        push(cyc + LAT, 3'b111, 3'b000, 3'b000, 3'b111);
        tick(10);
        bus.btn_i = 3'b000;
        push(cyc + LAT, 3'b000, 3'b111, 3'b000, 3'b000);
        tick(10);

        // Async reset while in PRESS_WAIT with the button held.
        bus.btn_i[BTN_ENTER] = 1'b1;
        tick(4);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_in_press_wait");
        tick(2);
        rst_n = 1'b1;
        push(cyc + LAT, 3'b001, 3'b000, 3'b000, 3'b001);
        tick(9);
        check("requalified_level", bus.btn_level, 3'b001);
        #2 rst_n = 1'b0;
        #1 check("reset_drops_level", bus.btn_level, 3'b000);
        bus.btn_i = '0;
        tick(2);
        rst_n = 1'b1;
        tick(10);

        // Long hold on reset-request; long pulse only when the feature is built in.
        bus.btn_i[BTN_RST] = 1'b1;
        c = cyc;
        push(c + LAT, 3'b100, 3'b000, 3'b000, 3'b100);
`ifdef BTN_LONGPRESS_EN
        push(c + LAT + LC, 3'b000, 3'b000, 3'b100, 3'b100);
`endif
        tick(40);
        bus.btn_i[BTN_RST] = 1'b0;
        push(cyc + LAT, 3'b000, 3'b100, 3'b000, 3'b000);
        tick(12);

        check("final_level", bus.btn_level, 3'b000);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events: got %0d unconsumed, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
